// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seven_seg_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_e;

  // Level that turns a digit off for the given anode polarity.
  function automatic logic digit_off_level(input bit active_low);
    return logic'(active_low);
  endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Per-slot cycle counter; flags the last blanking cycle and the last slot cycle.
module seg_slot_timer #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic blank_end,
  output logic slot_end
);

  localparam int CNT_W = $clog2(SCAN_DIV);

  logic [CNT_W-1:0] count;

  assign blank_end = (count == CNT_W'(BLANK_CYCLES - 1));
  assign slot_end  = (count == CNT_W'(SCAN_DIV - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || slot_end) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed scan controller for an N-digit seven-segment display with
// frame-boundary double buffering and leading-zero suppression.
module seven_segment_scanner
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS       = 4,
  parameter int SCAN_DIV         = 1000,
  parameter int BLANK_CYCLES     = 16,
  parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable,
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] value_in,
  input  logic                           value_load,
  input  logic                           blank_lz,
  output logic [NIBBLE_W-1:0]            seg_in,
  output logic [NUM_DIGITS-1:0]          digit_en,
  output logic                           frame_done
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int VAL_W = NIBBLE_W * NUM_DIGITS;
  localparam logic [NUM_DIGITS-1:0] EN_OFF = {NUM_DIGITS{digit_off_level(ANODE_ACTIVE_LOW)}};

  scan_state_e         state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [VAL_W-1:0]    disp_q, disp_d, pend_q;
  logic                flag_q;
  logic                transfer, wrap;
  logic                blank_end, slot_end;
  logic                lz_dark, higher_zero;
  logic [NUM_DIGITS-1:0] onehot;
  logic [NIBBLE_W-1:0] seg_d;
  logic [NUM_DIGITS-1:0] en_d;
  logic                fd_d;

  seg_slot_timer #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     ((state_q == IDLE) || !enable),
    .blank_end (blank_end),
    .slot_end  (slot_end)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    transfer = 1'b0;
    wrap     = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d  = BLANK;
          idx_d    = '0;
          transfer = 1'b1;
        end
        BLANK: if (blank_end) state_d = SHOW;
        SHOW: if (slot_end) begin
          state_d = BLANK;
          if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
            idx_d    = '0;
            transfer = 1'b1;
            wrap     = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are computed from next-cycle values so the registered outputs line up with the state.
  assign disp_d = (transfer && flag_q) ? pend_q : disp_q;

  always_comb begin
    lz_dark     = 1'b0;
    higher_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      higher_zero = higher_zero && (disp_d[i*NIBBLE_W +: NIBBLE_W] == '0);
      if (IDX_W'(i) == idx_d) lz_dark = blank_lz && higher_zero;
    end
  end

  always_comb begin
    onehot        = '0;
    onehot[idx_d] = 1'b1;
    seg_d         = '0;
    en_d          = EN_OFF;
    fd_d          = wrap;
    unique case (state_d)
      BLANK: seg_d = disp_d[idx_d*NIBBLE_W +: NIBBLE_W];
      SHOW: begin
        seg_d = disp_d[idx_d*NIBBLE_W +: NIBBLE_W];
        if (!lz_dark) en_d = EN_OFF ^ onehot;
      end
      default: ;
    endcase
  end

  // NOTE: the display and pending buffers are plain registers, so they reset with everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      disp_q     <= '0;
      pend_q     <= '0;
      flag_q     <= 1'b0;
      seg_in     <= '0;
      digit_en   <= EN_OFF;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      disp_q     <= disp_d;
      seg_in     <= seg_d;
      digit_en   <= en_d;
      frame_done <= fd_d;
      // A load on a boundary edge wins the flag; the boundary has already taken the old value.
      if (value_load) begin
        pend_q <= value_in;
        flag_q <= 1'b1;
      end else if (transfer) begin
        flag_q <= 1'b0;
      end
    end
  end

endmodule
